parking_ctrl_param: RTL and testbench

Parametrised next-generation parking controller. Tracks occupancy of NUM_SLOTS bays, assigns each entering car the lowest-numbered free bay, and drives a timed entry gate. Releases bays on exit and flags illegal exits and rejected entries. Sits between the gate/sensor front-end and the display/status logic.

---
 rtl/parking_pkg.sv | 24 ++
 rtl/parking_ctrl_param_slot_finder.sv | 28 ++
 rtl/parking_ctrl_param.sv | 168 ++++++++++++++++
 tb/tb_parking_ctrl_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and width helpers for the parking controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parking_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } gate_state_t;

    // Width of the saturating statistics counters (PARK_STATS_EN builds only).
    localparam int STATS_W = 16;

    // Bay index width; a 1-bit index is kept even for degenerate bay counts.
    function automatic int slot_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Free-bay count width; must hold the value n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/parking_ctrl_param_slot_finder.sv
// Lowest-index free-bay search over the free-bay bitmap.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of free_map.
//
// Ports: free_map (bit i = bay i free), free_idx (lowest free bay),
//        found (at least one bay is free).
module slot_finder #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2
) (
    input  logic [NUM_SLOTS-1:0] free_map,
    output logic [SLOT_W-1:0]    free_idx,
    output logic                 found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        free_idx = '0;
        found    = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_map[i]) begin
                free_idx = SLOT_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_ctrl_param.sv
// Parking bay allocator with timed entry gate, exit release and error pulses.
// Latency: outputs update one clk after the rising edge of a sensor is detected.
// Backpressure: none; entries while the gate is open or the lot is full are rejected.
//
// Ports: clk, reset (async active-low), entry_signal / exit_signal (level sensors),
//        exit_slot (bay being vacated), is_open, is_full, spots (occupancy bitmap),
//        capacity (free bays), location (last assigned bay), entry_reject, exit_error.
// Build option: define PARK_STATS_EN to add total_entries / total_rejects counters.
module parking_ctrl_param
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS        = 4,
    parameter int GATE_OPEN_CYCLES = 3,
    parameter int SLOT_W           = slot_w(NUM_SLOTS),
    parameter int CNT_W            = cnt_w(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 entry_signal,
    input  logic                 exit_signal,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic                 is_open,
    output logic                 is_full,
    output logic [NUM_SLOTS-1:0] spots,
    output logic [CNT_W-1:0]     capacity,
    output logic [SLOT_W-1:0]    location,
    output logic                 entry_reject,
    output logic                 exit_error
`ifdef PARK_STATS_EN
    ,
    output logic [STATS_W-1:0]   total_entries,
    output logic [STATS_W-1:0]   total_rejects
`endif
);

    localparam int TMR_W = $clog2(GATE_OPEN_CYCLES + 1);

    gate_state_t            state;
    logic [TMR_W-1:0]       timer;

    // Sensor history and the registered edge pulses acted on one cycle later.
    logic                   entry_q;
    logic                   exit_q;
    logic                   entry_edge_r;
    logic                   exit_edge_r;
    logic [SLOT_W-1:0]      exit_slot_r;

    logic [NUM_SLOTS-1:0]   exit_mask;
    logic [NUM_SLOTS-1:0]   alloc_mask;
    logic [NUM_SLOTS-1:0]   spots_post;
    logic [NUM_SLOTS-1:0]   free_map;
    logic [SLOT_W-1:0]      free_idx;
    logic                   free_found;
    logic                   exit_hit;
    logic                   exit_ok;
    logic                   alloc;
    logic                   reject;
    logic [CNT_W-1:0]       cap_next;

    // One-hot decode of the vacated bay; an out-of-range index decodes to zero,
    // so it can never match an occupied bay and falls through to exit_error.
    always_comb begin
        exit_mask = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            exit_mask[i] = (exit_slot_r == SLOT_W'(i));
        end
    end

    assign exit_hit   = |(exit_mask & spots);
    assign exit_ok    = exit_edge_r & exit_hit;

    // Exit is applied before allocation so a full lot can reuse the bay freed
    // in the same cycle.
    assign spots_post = exit_ok ? (spots & ~exit_mask) : spots;
    assign free_map   = ~spots_post;

    slot_finder #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_slot_finder (
        .free_map  (free_map),
        .free_idx  (free_idx),
        .found     (free_found)
    );

    assign alloc  = entry_edge_r & (state == IDLE) & free_found;
    assign reject = entry_edge_r & ~alloc;

    always_comb begin
        alloc_mask = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            alloc_mask[i] = alloc & (free_idx == SLOT_W'(i));
        end
    end

    assign cap_next = capacity + CNT_W'(exit_ok) - CNT_W'(alloc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            timer         <= '0;
            entry_q       <= 1'b0;
            exit_q        <= 1'b0;
            entry_edge_r  <= 1'b0;
            exit_edge_r   <= 1'b0;
            exit_slot_r   <= '0;
            spots         <= '0;
            capacity      <= CNT_W'(NUM_SLOTS);
            is_full       <= 1'b0;
            is_open       <= 1'b0;
            location      <= '0;
            entry_reject  <= 1'b0;
            exit_error    <= 1'b0;
`ifdef PARK_STATS_EN
            total_entries <= '0;
            total_rejects <= '0;
`endif
        end else begin
            entry_q      <= entry_signal;
            exit_q       <= exit_signal;
            entry_edge_r <= entry_signal & ~entry_q;
            exit_edge_r  <= exit_signal & ~exit_q;
            if (exit_signal && !exit_q) begin
                exit_slot_r <= exit_slot;
            end

            spots        <= spots_post | alloc_mask;
            capacity     <= cap_next;
            is_full      <= (cap_next == '0);
            entry_reject <= reject;
            exit_error   <= exit_edge_r & ~exit_hit;

            case (state)
                IDLE: begin
                    if (alloc) begin
                        state    <= OPEN;
                        timer    <= TMR_W'(GATE_OPEN_CYCLES);
                        is_open  <= 1'b1;
                        location <= free_idx;
                    end
                end
                OPEN: begin
                    // Timer holds the remaining open cycles including this one.
                    if (timer <= TMR_W'(1)) begin
                        state   <= IDLE;
                        is_open <= 1'b0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    is_open <= 1'b0;
                end
            endcase

`ifdef PARK_STATS_EN
            if (alloc && (total_entries != '1)) begin
                total_entries <= total_entries + 1'b1;
            end
            if (reject && (total_rejects != '1)) begin
                total_rejects <= total_rejects + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_parking_ctrl_param.sv
// Directed bench for parking_ctrl_param (NUM_SLOTS=4, GATE_OPEN_CYCLES=3).
// Table of sensor events with expected end state and pulse counts, plus
// hand-written sequences for the gate-open reject and asynchronous reset.
module tb_parking_ctrl_param;

    logic       clk;
    logic       reset;
    logic       entry_signal;
    logic       exit_signal;
    logic [1:0] exit_slot;
    logic       is_open;
    logic       is_full;
    logic [3:0] spots;
    logic [2:0] capacity;
    logic [1:0] location;
    logic       entry_reject;
    logic       exit_error;
`ifdef PARK_STATS_EN
    logic [15:0] total_entries;
    logic [15:0] total_rejects;
`endif

    int total;
    int bad;

    parking_ctrl_param #(
        .NUM_SLOTS        (4),
        .GATE_OPEN_CYCLES (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .entry_signal (entry_signal),
        .exit_signal  (exit_signal),
        .exit_slot    (exit_slot),
        .is_open      (is_open),
        .is_full      (is_full),
        .spots        (spots),
        .capacity     (capacity),
        .location     (location),
        .entry_reject (entry_reject),
        .exit_error   (exit_error)
`ifdef PARK_STATS_EN
        ,
        .total_entries (total_entries),
        .total_rejects (total_rejects)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ent;
        logic       ext;
        logic [1:0] slot;
        int         hold;
        logic [3:0] e_spots;
        int         e_cap;
        logic       e_full;
        int         e_loc;
        int         e_open;
        int         e_rej;
        int         e_err;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one sensor event for 'hold' cycles, then idle; count every cycle
    // of is_open / entry_reject / exit_error across the whole window.
    task automatic apply(input string nm, input vec_t v);
        int n_open;
        int n_rej;
        int n_err;
        n_open = 0;
        n_rej  = 0;
        n_err  = 0;
        entry_signal = v.ent;
        exit_signal  = v.ext;
        exit_slot    = v.slot;
        for (int c = 0; c < v.hold + 7; c++) begin
            tick();
            if (c == v.hold - 1) begin
                entry_signal = 1'b0;
                exit_signal  = 1'b0;
            end
            n_open += int'(is_open);
            n_rej  += int'(entry_reject);
            n_err  += int'(exit_error);
        end
        chk({nm, " spots"},    int'(spots),    int'(v.e_spots));
        chk({nm, " capacity"}, int'(capacity), v.e_cap);
        chk({nm, " is_full"},  int'(is_full),  int'(v.e_full));
        chk({nm, " location"}, int'(location), v.e_loc);
        chk({nm, " open_cyc"}, n_open,         v.e_open);
        chk({nm, " rejects"},  n_rej,          v.e_rej);
        chk({nm, " errors"},   n_err,          v.e_err);
    endtask

    initial begin
        int n_open;
        int n_rej;
        total = 0;
        bad   = 0;

        //            ent   ext   slot hold spots  cap full loc open rej err
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 1, 4'b0001, 3, 1'b0, 0, 3, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 1, 4'b0011, 2, 1'b0, 1, 3, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 1, 4'b0111, 1, 1'b0, 2, 3, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 1, 4'b1111, 0, 1'b1, 3, 3, 0, 0};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 1, 4'b1111, 0, 1'b1, 3, 0, 1, 0};
        vecs[5]  = '{1'b0, 1'b1, 2'd2, 1, 4'b1011, 1, 1'b0, 3, 0, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 2'd0, 1, 4'b1111, 0, 1'b1, 2, 3, 0, 0};
        vecs[7]  = '{1'b0, 1'b1, 2'd1, 1, 4'b1101, 1, 1'b0, 2, 0, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 1, 4'b1101, 1, 1'b0, 2, 0, 0, 1};
        vecs[9]  = '{1'b1, 1'b0, 2'd0, 10, 4'b1111, 0, 1'b1, 1, 3, 0, 0};
        vecs[10] = '{1'b1, 1'b1, 2'd0, 1, 4'b1111, 0, 1'b1, 0, 3, 0, 0};
        vecs[11] = '{1'b0, 1'b1, 2'd3, 1, 4'b0111, 1, 1'b0, 0, 0, 0, 0};

        entry_signal = 1'b0;
        exit_signal  = 1'b0;
        exit_slot    = 2'd0;
        reset        = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        chk("reset spots",    int'(spots),    0);
        chk("reset capacity", int'(capacity), 4);
        chk("reset is_full",  int'(is_full),  0);
        chk("reset is_open",  int'(is_open),  0);
        chk("reset location", int'(location), 0);
`ifdef PARK_STATS_EN
        chk("reset entries", int'(total_entries), 0);
        chk("reset rejects", int'(total_rejects), 0);
`endif

        for (int i = 0; i < 7; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end
`ifdef PARK_STATS_EN
        chk("stats entries", int'(total_entries), 5);
        chk("stats rejects", int'(total_rejects), 1);
`endif
        for (int i = 7; i < NV; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Second entry edge while the gate is still open: one allocation only.
        n_open = 0;
        n_rej  = 0;
        for (int c = 0; c < 11; c++) begin
            entry_signal = (c == 0 || c == 2);
            tick();
            n_open += int'(is_open);
            n_rej  += int'(entry_reject);
        end
        entry_signal = 1'b0;
        chk("open_rej spots",    int'(spots),    4'b1111);
        chk("open_rej capacity", int'(capacity), 0);
        chk("open_rej location", int'(location), 3);
        chk("open_rej open_cyc", n_open,         3);
        chk("open_rej rejects",  n_rej,          1);

        // Free bay 0, admit a car, then pull reset between clock edges.
        apply("free0", '{1'b0, 1'b1, 2'd0, 1, 4'b1110, 1, 1'b0, 3, 0, 0, 0});
        entry_signal = 1'b1;
        tick();
        entry_signal = 1'b0;
        tick();
        chk("pre_rst is_open",  int'(is_open),  1);
        chk("pre_rst location", int'(location), 0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst is_open",  int'(is_open),      0);
        chk("async_rst spots",    int'(spots),        0);
        chk("async_rst capacity", int'(capacity),     4);
        chk("async_rst is_full",  int'(is_full),      0);
        chk("async_rst location", int'(location),     0);
        chk("async_rst reject",   int'(entry_reject), 0);
        chk("async_rst error",    int'(exit_error),   0);
`ifdef PARK_STATS_EN
        chk("async_rst entries", int'(total_entries), 0);
`endif
        tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("post_rst is_open", int'(is_open), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
